instr_buffer: RTL and testbench

- Instruction buffer that answers the top-level controller's instruction-fetch protocol.
- On a fetch request while empty, it burst-reads instruction words from external DDR through a simple request/ack/valid read port and stores them in a 1024×64 on-chip memory.
- It serves the controller's address/read-enable reads with one-cycle latency.
- It drives the controller's `i_mem_empty` input and sits between the top FSM and the DDR read channel.

---
 rtl/instr_buffer_if.sv | 43 ++++
 rtl/instr_buffer.sv | 112 +++++++++++
 tb/tb_instr_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_buffer_if.sv
// ----------------------------------------------------------------------------
// instr_buffer_if
// Bundles the instruction buffer's two sides into one port:
//   controller side : fetch_req, i_mem_addr, i_mem_rd_enable -> i_mem_dout,
//                     i_mem_empty, fetch_done
//   DDR read side   : ddr_rd_req/addr/len -> ddr_rd_ack, ddr_rd_valid,
//                     ddr_rd_data
// slave  : the buffer itself
// master : the environment (controller + DDR read channel)
// ----------------------------------------------------------------------------
interface instr_buffer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int DDR_AW = 32
) ();
    logic              fetch_req;
    logic [ADDR_W-1:0] i_mem_addr;
    logic              i_mem_rd_enable;
    logic [DATA_W-1:0] i_mem_dout;
    logic              i_mem_empty;
    logic              fetch_done;

    logic              ddr_rd_req;
    logic [DDR_AW-1:0] ddr_rd_addr;
    logic [15:0]       ddr_rd_len;
    logic              ddr_rd_ack;
    logic              ddr_rd_valid;
    logic [DATA_W-1:0] ddr_rd_data;

    modport slave (
        input  fetch_req, i_mem_addr, i_mem_rd_enable,
               ddr_rd_ack, ddr_rd_valid, ddr_rd_data,
        output i_mem_dout, i_mem_empty, fetch_done,
               ddr_rd_req, ddr_rd_addr, ddr_rd_len
    );

    modport master (
        output fetch_req, i_mem_addr, i_mem_rd_enable,
               ddr_rd_ack, ddr_rd_valid, ddr_rd_data,
        input  i_mem_dout, i_mem_empty, fetch_done,
               ddr_rd_req, ddr_rd_addr, ddr_rd_len
    );
endinterface

// File: rtl/instr_buffer.sv
// ----------------------------------------------------------------------------
// instr_buffer
// On-chip instruction store (2^ADDR_W x DATA_W) refilled from DDR in bursts
// of BURST_LEN words whenever the controller asks for more and has consumed
// everything loaded so far (its read address has caught up with wr_ptr).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : instr_buffer_if.slave (controller read port + DDR read channel)
// ----------------------------------------------------------------------------
module instr_buffer #(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 64,
    parameter int                DDR_AW     = 32,
    parameter int                BURST_LEN  = 16,
    parameter logic [DDR_AW-1:0] INSTR_BASE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_buffer_if.slave        bus
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [DDR_AW-1:0] ADDR_STEP = DDR_AW'(BURST_LEN * (DATA_W / 8));
    localparam logic [ADDR_W:0]   LAST_BEAT = (ADDR_W + 1)'(BURST_LEN - 1);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        RECV = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     beat_cnt_q, beat_cnt_d;
    logic [DDR_AW-1:0]   ddr_rd_addr_q, ddr_rd_addr_d;
    logic [DATA_W-1:0]   i_mem_dout_q, i_mem_dout_d;
    logic                mem_we;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            ddr_rd_addr_q <= INSTR_BASE;
            i_mem_dout_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            ddr_rd_addr_q <= ddr_rd_addr_d;
            i_mem_dout_q  <= i_mem_dout_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= bus.ddr_rd_data;
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        ddr_rd_addr_d = ddr_rd_addr_q;
        mem_we        = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Only refill once every loaded word has been consumed, so a
                // burst can never overwrite unread instructions.
                if (bus.fetch_req && (wr_ptr_q == bus.i_mem_addr)) state_d = REQ;
            end
            REQ: begin
                if (bus.ddr_rd_ack) begin
                    beat_cnt_d = '0;
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (bus.ddr_rd_valid) begin
                    mem_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q + (ADDR_W + 1)'(1);
                    if (beat_cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE: begin
                ddr_rd_addr_d = ddr_rd_addr_q + ADDR_STEP;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered read port: data holds when no read is strobed.
    always_comb begin
        i_mem_dout_d = i_mem_dout_q;
        if (bus.i_mem_rd_enable) i_mem_dout_d = mem[bus.i_mem_addr];
    end

    assign bus.ddr_rd_req  = (state_q == REQ);
    assign bus.ddr_rd_addr = ddr_rd_addr_q;
    assign bus.ddr_rd_len  = 16'(BURST_LEN);
    assign bus.fetch_done  = (state_q == DONE);
    assign bus.i_mem_dout  = i_mem_dout_q;
    // Held high for the whole load so a partial burst is never consumed.
    assign bus.i_mem_empty = (state_q != IDLE) || (wr_ptr_q == bus.i_mem_addr);

endmodule

// File: tb/tb_instr_buffer.sv
module tb_instr_buffer;
    localparam int          AW    = 10;
    localparam int          DW    = 64;
    localparam int          BL    = 16;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_buffer_if #(.ADDR_W(AW), .DATA_W(DW), .DDR_AW(32)) bus ();

    instr_buffer #(
        .ADDR_W(AW), .DATA_W(DW), .DDR_AW(32), .BURST_LEN(BL), .INSTR_BASE(BASE)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: expected memory image, write pointer, next DDR address.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr;
    logic [31:0]   m_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full fetch from the controller's point of view.
    task automatic fetch(input int ack_dly, input bit gaps, input bit seq_data, input bit junk);
        logic [DW-1:0] d;
        int            fd;
        fd = 0;
        bus.i_mem_addr = AW'(m_ptr);
        bus.fetch_req  = 1'b1;
        tick();
        chk("req_rise", bus.ddr_rd_req, 1);
        chk("req_addr", bus.ddr_rd_addr, m_addr);
        chk("req_len",  bus.ddr_rd_len, BL);
        chk("req_empty", bus.i_mem_empty, 1);
        bus.fetch_req = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
            // beats before the ack must not be stored
            if (junk) begin
                bus.ddr_rd_valid = 1'b1;
                bus.ddr_rd_data  = {$urandom, $urandom};
            end
            tick();
        end
        bus.ddr_rd_valid = 1'b0;
        chk("req_hold", bus.ddr_rd_req, 1);
        bus.ddr_rd_ack = 1'b1;
        tick();
        bus.ddr_rd_ack = 1'b0;
        chk("req_drop", bus.ddr_rd_req, 0);
        for (int i = 0; i < BL; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.ddr_rd_valid = 1'b0;
                    tick();
                    fd += int'(bus.fetch_done);
                end
            end
            d = seq_data ? DW'(32'h1000 + i) : {$urandom, $urandom};
            bus.ddr_rd_valid = 1'b1;
            bus.ddr_rd_data  = d;
            tick();
            if (i != BL - 1) begin
                fd += int'(bus.fetch_done);
                chk("load_empty", bus.i_mem_empty, 1);
            end
            m_mem[m_ptr] = d;
            m_ptr = (m_ptr + 1) % DEPTH;
        end
        bus.ddr_rd_valid = 1'b0;
        chk("done_early", fd, 0);
        chk("done_pulse", bus.fetch_done, 1);
        chk("done_empty", bus.i_mem_empty, 1);
        tick();
        chk("done_once", bus.fetch_done, 0);
        chk("empty_fall", bus.i_mem_empty, 0);
        chk("wr_ptr", dut.wr_ptr_q, m_ptr);
        m_addr = m_addr + 32'(BL * (DW / 8));
    endtask

    // One-cycle-latency read, then confirm the data holds without a strobe.
    task automatic rd(input int a);
        bus.i_mem_addr      = AW'(a);
        bus.i_mem_rd_enable = 1'b1;
        tick();
        bus.i_mem_rd_enable = 1'b0;
        chk("rd_data", bus.i_mem_dout, m_mem[a]);
        chk("rd_empty", bus.i_mem_empty, (a == m_ptr) ? 1 : 0);
        bus.i_mem_addr = AW'(a + 1);
        tick();
        chk("rd_hold", bus.i_mem_dout, m_mem[a]);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        bus.fetch_req       = 1'b0;
        bus.i_mem_addr      = '0;
        bus.i_mem_rd_enable = 1'b0;
        bus.ddr_rd_ack      = 1'b0;
        bus.ddr_rd_valid    = 1'b0;
        bus.ddr_rd_data     = '0;
        m_ptr  = 0;
        m_addr = BASE;

        // Reset state
        repeat (3) tick();
        chk("rst_req",   bus.ddr_rd_req, 0);
        chk("rst_done",  bus.fetch_done, 0);
        chk("rst_addr",  bus.ddr_rd_addr, BASE);
        chk("rst_len",   bus.ddr_rd_len, BL);
        chk("rst_dout",  bus.i_mem_dout, 0);
        chk("rst_empty", bus.i_mem_empty, 1);
        rst_n = 1'b1;
        tick();

        // First fetch: ack after 2 cycles, data 0x1000+i
        fetch(2, 1'b0, 1'b1, 1'b0);
        for (int a = 0; a < BL; a++) rd(a);

        // Request while not empty is ignored
        bus.i_mem_addr = AW'(5);
        bus.fetch_req  = 1'b1;
        repeat (4) begin
            tick();
            chk("ne_req", bus.ddr_rd_req, 0);
        end
        bus.fetch_req = 1'b0;

        // Second fetch lands at 16..31 from DDR 0x80
        fetch(0, 1'b0, 1'b0, 1'b0);
        for (int a = 16; a < 32; a++) rd(a);

        // Spurious valid/ack while idle
        bus.i_mem_addr = AW'(m_ptr);
        for (int i = 0; i < 6; i++) begin
            bus.ddr_rd_valid = 1'($urandom_range(0, 1));
            bus.ddr_rd_ack   = 1'($urandom_range(0, 1));
            bus.ddr_rd_data  = {$urandom, $urandom};
            tick();
            chk("sp_req", bus.ddr_rd_req, 0);
        end
        bus.ddr_rd_valid = 1'b0;
        bus.ddr_rd_ack   = 1'b0;
        tick();
        chk("sp_ptr", dut.wr_ptr_q, m_ptr);

        // Gapped beats with junk valids before the ack
        fetch(3, 1'b1, 1'b0, 1'b1);
        for (int a = 32; a < 48; a++) rd(a);
        rd(31);

        // Fill to 64 bursts total; wr_ptr wraps back to 0
        for (int b = 3; b < 64; b++) begin
            if (b == 63) chk("pre_wrap_ptr", dut.wr_ptr_q, 1008);
            fetch($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end
        chk("wrap_ptr", dut.wr_ptr_q, 0);
        for (int a = 1008; a < 1024; a++) rd(a);
        for (int i = 0; i < 8; i++) rd($urandom_range(0, DEPTH - 2));

        // 65th request starts at 0x2000
        chk("addr_65", m_addr, 32'h2000);
        fetch(1, 1'b0, 1'b0, 1'b0);

        // Reset during RECV after 7 beats
        bus.i_mem_addr = AW'(m_ptr);
        bus.fetch_req  = 1'b1;
        tick();
        bus.fetch_req  = 1'b0;
        bus.ddr_rd_ack = 1'b1;
        tick();
        bus.ddr_rd_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.ddr_rd_valid = 1'b1;
            bus.ddr_rd_data  = {$urandom, $urandom};
            m_mem[m_ptr + i] = bus.ddr_rd_data;
            tick();
        end
        bus.i_mem_addr = '0;
        rst_n = 1'b0;
        #1;
        chk("mr_req",   bus.ddr_rd_req, 0);
        chk("mr_done",  bus.fetch_done, 0);
        chk("mr_addr",  bus.ddr_rd_addr, BASE);
        chk("mr_dout",  bus.i_mem_dout, 0);
        chk("mr_empty", bus.i_mem_empty, 1);
        chk("mr_ptr",   dut.wr_ptr_q, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.ddr_rd_data = {$urandom, $urandom};
            tick();
        end
        bus.ddr_rd_valid = 1'b0;
        chk("mr_ign_ptr", dut.wr_ptr_q, 0);
        chk("mr_ign_req", bus.ddr_rd_req, 0);
        m_ptr  = 0;
        m_addr = BASE;
        fetch(0, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < 24; a++) rd(a);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
